spi_cmd_arbiter: RTL and testbench

//  Shares one SPI master command port among NUM_REQ requesters (controller, data mgmt, sensor FSM).

---
 rtl/spi_cmd_arbiter.sv | 151 +++++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_arbiter.sv
// spi_cmd_arbiter: round-robin sharing of one SPI master command port, with response routing and a timeout
module spi_cmd_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          m_cmd_valid,
  output logic                          m_cmd_write,
  output logic [ADDR_WIDTH-1:0]         m_cmd_addr,
  output logic [DATA_WIDTH-1:0]         m_cmd_wdata,
  input  logic                          m_resp_valid,
  input  logic [DATA_WIDTH-1:0]         m_resp_rdata
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          ptr_q, ptr_d, grant_q, grant_d, win, cand;
  logic [TW-1:0]          timer_q, timer_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d, cmd_wdata_q, cmd_wdata_d;
  logic [ADDR_WIDTH-1:0]  cmd_addr_q, cmd_addr_d;
  logic                   rsp_err_q, rsp_err_d, busy_q, busy_d;
  logic                   cmd_valid_q, cmd_valid_d, cmd_write_q, cmd_write_d;
  logic                   found;
  logic [ADDR_WIDTH-1:0]  addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0]  wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search upward from ptr+1, wrapping; the last candidate is ptr itself.
  always_comb begin
    win   = ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (ptr_q >= GW'(NUM_REQ - k)) ? ptr_q - GW'(NUM_REQ - k) : ptr_q + GW'(k);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    timer_d     = timer_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    busy_d      = busy_q;
    cmd_valid_d = 1'b0;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    case (state_q)
      IDLE: if (found) begin
        state_d     = ISSUE;
        ptr_d       = win;
        grant_d     = win;
        cmd_valid_d = 1'b1;
        req_ready_d = NUM_REQ'(1) << win;
        busy_d      = 1'b1;
        cmd_write_d = req_write[win];
        cmd_addr_d  = addr_a[win];
        cmd_wdata_d = wdata_a[win];
      end
      ISSUE: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: if (m_resp_valid || timer_q == LAST) begin
        // A response arriving on the expiry cycle still counts as a normal completion.
        state_d     = IDLE;
        busy_d      = 1'b0;
        timer_d     = '0;
        rsp_valid_d = NUM_REQ'(1) << grant_q;
        rsp_rdata_d = m_resp_valid ? m_resp_rdata : '0;
        rsp_err_d   = !m_resp_valid;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= GW'(NUM_REQ - 1);
      grant_q     <= '0;
      timer_q     <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      timer_q     <= timer_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign m_cmd_valid = cmd_valid_q;
  assign m_cmd_write = cmd_write_q;
  assign m_cmd_addr  = cmd_addr_q;
  assign m_cmd_wdata = cmd_wdata_q;
endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// tb_spi_cmd_arbiter: scoreboard bench with randomized requesters, a stub SPI master and a
// transaction-level reference model predicting each command and completion with its cycle.
module tb_spi_cmd_arbiter;
  localparam int N = 3, AW = 14, DW = 8, T = 64;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0, req_write = '0;
  logic [AW-1:0]     ad [N];
  logic [DW-1:0]     wd [N];
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      req_ready, rsp_valid;
  logic [DW-1:0]     rsp_rdata, m_cmd_wdata, m_resp_rdata = '0;
  logic              rsp_err, busy, m_cmd_valid, m_cmd_write, m_resp_valid = 1'b0;
  logic [1:0]        grant_id;
  logic [AW-1:0]     m_cmd_addr;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_addr[g*AW +: AW]  = ad[g];
    assign req_wdata[g*DW +: DW] = wd[g];
  end

  spi_cmd_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .grant_id(grant_id), .m_cmd_valid(m_cmd_valid),
    .m_cmd_write(m_cmd_write), .m_cmd_addr(m_cmd_addr), .m_cmd_wdata(m_cmd_wdata),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            id;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          err;
    int            cyc;
  } ev_t;

  ev_t cq[$], rq[$];
  int  dlog[$];
  int  checks = 0, errs = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a command or a completion.
  ev_t           last_cmd;
  bit            outst = 0;
  int            last_cmd_cyc = 0, last_rsp_cyc = 0;
  logic          last_err = 1'b0;
  logic [DW-1:0] last_rdata = '0;

  always @(negedge clk) if (rst_n) begin
    ev_t e;
    while (cq.size() > 0 && cq[0].cyc < cyc) begin
      e = cq.pop_front();
      chk("cmd_missing", cyc, e.cyc);
    end
    while (rq.size() > 0 && rq[0].cyc < cyc) begin
      e = rq.pop_front();
      chk("rsp_missing", cyc, e.cyc);
    end
    if (m_cmd_valid || req_ready != 0) begin
      if (cq.size() == 0) chk("cmd_unexpected", {m_cmd_valid, req_ready}, 0);
      else begin
        e = cq.pop_front();
        chk("cmd_cycle", cyc, e.cyc);
        chk("cmd_valid", m_cmd_valid, 1);
        chk("req_ready", req_ready, 1 << e.id);
        chk("grant_id", grant_id, e.id);
        chk("cmd_write", m_cmd_write, e.wr);
        chk("cmd_addr", m_cmd_addr, e.a);
        chk("cmd_wdata", m_cmd_wdata, e.d);
        chk("busy_issue", busy, 1);
        chk("rsp_before_next_cmd", outst, 0);
        outst = 1;
        last_cmd = e;
        last_cmd_cyc = cyc;
        dlog.push_back(int'(grant_id));
      end
    end
    if (rsp_valid != 0) begin
      if (rq.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        e = rq.pop_front();
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_valid", rsp_valid, 1 << e.id);
        chk("rsp_err", rsp_err, e.err);
        if (e.err || !e.wr) chk("rsp_rdata", rsp_rdata, e.d);
        chk("busy_rsp", busy, 0);
        chk("cmd_hold_write", m_cmd_write, last_cmd.wr);
        chk("cmd_hold_addr", m_cmd_addr, last_cmd.a);
        chk("cmd_hold_wdata", m_cmd_wdata, last_cmd.d);
        outst = 0;
        last_rsp_cyc = cyc;
        last_err = rsp_err;
        last_rdata = rsp_rdata;
      end
    end
  end

  // Reference model: ph 0 = port free, 1 = command being issued, 2 = awaiting response for cnt cycles.
  int            ph = 0, cnt = 0, resp_at = 0, ptr = N - 1, owner = 0, force_at = -2;
  logic          own_wr = 1'b0;
  bit            sticky [N];
  bit            rnd = 0, force_stray = 0, rd_fix = 0;
  logic [DW-1:0] rd_val = '0;

  task automatic raise(int i, logic w, logic [AW-1:0] a, logic [DW-1:0] d, bit s);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    ad[i] = a;
    wd[i] = d;
    sticky[i] = s;
  endtask

  function automatic int pick();
    for (int k = 1; k <= N; k++) if (req_valid[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int pick_delay();
    int r = $urandom_range(9);
    return (r < 2) ? -1 : (r == 2) ? T - 1 : $urandom_range(30);
  endfunction

  task automatic tick();
    int w;
    int drop = -1;
    if (rnd) for (int i = 0; i < N; i++) begin
      if (!req_valid[i]) begin
        if ($urandom_range(3) == 0)
          raise(i, 1'($urandom_range(1)), AW'($urandom), DW'($urandom), 1'($urandom_range(1)));
      end else if ($urandom_range(31) == 0) req_valid[i] = 1'b0;
    end
    m_resp_rdata = rd_fix ? rd_val : DW'($urandom);
    m_resp_valid = (ph == 2 && cnt == resp_at) ||
                   (ph == 0 && (force_stray || (rnd && $urandom_range(7) == 0)));
    case (ph)
      0: begin
        w = pick();
        if (w >= 0) begin
          cq.push_back('{w, req_write[w], ad[w], wd[w], 1'b0, cyc + 1});
          ptr = w;
          owner = w;
          own_wr = req_write[w];
          ph = 1;
          if (!sticky[w]) drop = w;
        end
      end
      1: begin
        ph = 2;
        cnt = 0;
        resp_at = (force_at > -2) ? force_at : pick_delay();
      end
      default: begin
        if (m_resp_valid) begin
          rq.push_back('{owner, own_wr, '0, m_resp_rdata, 1'b0, cyc + 1});
          ph = 0;
        end else if (cnt == T - 1) begin
          rq.push_back('{owner, own_wr, '0, '0, 1'b1, cyc + 1});
          ph = 0;
        end else cnt++;
      end
    endcase
    @(posedge clk);
    #1;
    if (drop >= 0) req_valid[drop] = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while (!(ph == 0 && req_valid == 0) && n < 1000) begin
      tick();
      n++;
    end
    chk("settle_bound", 32'(n < 1000), 1);
    tick();
    tick();
  endtask

  task automatic grants(int k);
    int g0 = dlog.size();
    int n = 0;
    while (dlog.size() < g0 + k && n < 2000) begin
      tick();
      n++;
    end
    chk("grant_bound", 32'(n < 2000), 1);
  endtask

  initial begin
    int g0, n;
    for (int i = 0; i < N; i++) begin
      ad[i] = '0;
      wd[i] = '0;
      sticky[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {req_ready, rsp_valid, rsp_err, busy, grant_id, m_cmd_valid, m_cmd_write}, 0);
    chk("rst_data", {rsp_rdata, m_cmd_addr, m_cmd_wdata}, 0);
    rst_n = 1'b1;

    // All three requesting continuously: round-robin from requester 0.
    force_at = 3;
    g0 = dlog.size();
    for (int i = 0; i < N; i++) raise(i, 1'($urandom_range(1)), AW'($urandom), DW'($urandom), 1);
    grants(5);
    req_valid = '0;
    settle();
    for (int i = 0; i < 5; i++) chk("rr_order", dlog[g0 + i], i % 3);

    // Write then read from requester 0, master answering 60 cycles after cmd_valid.
    force_at = 59;
    rd_fix = 1;
    rd_val = 8'h3C;
    raise(0, 1'b1, 14'h0012, 8'hA5, 0);
    settle();
    raise(0, 1'b0, 14'h0012, 8'h00, 0);
    settle();
    chk("resp_latency", last_rsp_cyc - last_cmd_cyc, 61);
    chk("resp_rdata", last_rdata, 8'h3C);
    rd_fix = 0;

    // Requester 1 repeating; requester 2 arrives during its wait.
    force_at = 10;
    g0 = dlog.size();
    raise(1, 1'b0, AW'($urandom), DW'($urandom), 1);
    n = 0;
    while (ph != 2 && n < 100) begin
      tick();
      n++;
    end
    raise(2, 1'b1, AW'($urandom), DW'($urandom), 0);
    grants(3);
    req_valid = '0;
    settle();
    chk("late_req_0", dlog[g0], 1);
    chk("late_req_1", dlog[g0 + 1], 2);
    chk("late_req_2", dlog[g0 + 2], 1);

    // Timeout with no response, then a response coinciding with expiry.
    force_at = -1;
    raise(0, 1'b0, AW'($urandom), DW'($urandom), 0);
    settle();
    chk("timeout_latency", last_rsp_cyc - last_cmd_cyc, 65);
    chk("timeout_err", last_err, 1);
    force_at = T - 1;
    raise(2, 1'b0, AW'($urandom), DW'($urandom), 0);
    settle();
    chk("expiry_tie_latency", last_rsp_cyc - last_cmd_cyc, 65);
    chk("expiry_tie_err", last_err, 0);

    // Reset in the middle of a wait, then a stray response and a fresh arbitration.
    force_at = -1;
    raise(0, 1'b0, AW'($urandom), DW'($urandom), 0);
    n = 0;
    while (!(ph == 2 && cnt == 5) && n < 100) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", {req_ready, rsp_valid, rsp_err, busy, grant_id, m_cmd_valid, m_cmd_write}, 0);
    chk("abort_data", {rsp_rdata, m_cmd_addr, m_cmd_wdata}, 0);
    cq.delete();
    rq.delete();
    outst = 0;
    ph = 0;
    ptr = N - 1;
    req_valid = '0;
    m_resp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    force_stray = 1;
    repeat (3) tick();
    force_stray = 0;
    force_at = 2;
    g0 = dlog.size();
    raise(1, 1'b1, AW'($urandom), DW'($urandom), 0);
    raise(2, 1'b0, AW'($urandom), DW'($urandom), 0);
    settle();
    chk("post_reset_first", dlog[g0], 1);
    chk("post_reset_second", dlog[g0 + 1], 2);

    // Randomized traffic with stray responses and random drops.
    force_at = -2;
    rnd = 1;
    repeat (1500) tick();
    rnd = 0;
    req_valid = '0;
    settle();
    chk("cmdq_empty", cq.size(), 0);
    chk("rspq_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
